// File: rtl/decode_scoreboard.sv
// ---------------------------------------------------------------------------
// decode_scoreboard
//
// Purpose: register-write scoreboard for an in-order decode stage. Each
// architectural register 1..31 carries a 2-bit count of writes that have been
// issued but not yet written back. Decode is stalled on a RAW hazard (a source
// register with a write outstanding) or when the destination counter is
// already saturated. Register 0 is hard-wired and never tracked.
//
// Ports:
//   clk            in   single clock, rising-edge
//   reset          in   asynchronous active-low reset
//   issue_valid    in   decode holds a valid instruction
//   rs, rt         in   source register numbers [4:0]
//   uses_rs/rt     in   instruction reads rs / rt
//   dest           in   destination register [4:0]
//   dest_we        in   instruction will write dest
//   regwrite_WB    in   writeback is writing the register file
//   writereg_WB    in   writeback destination register [4:0]
//   flush          in   synchronous pipeline flush, clears all counters
//   stall          out  hold decode and earlier stages
//   issue_accept   out  instruction leaves decode this cycle
//   pending_any    out  at least one register has a write in flight
//   stall_cycles   out  saturating count of stalled cycles [15:0]
//   err_underflow  out  sticky: writeback seen with no write outstanding
// ---------------------------------------------------------------------------
module decode_scoreboard (
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic        uses_rs,
   input  logic        uses_rt,
   input  logic [4:0]  dest,
   input  logic        dest_we,
   input  logic        regwrite_WB,
   input  logic [4:0]  writereg_WB,
   input  logic        flush,
   output logic        stall,
   output logic        issue_accept,
   output logic        pending_any,
   output logic [15:0] stall_cycles,
   output logic        err_underflow
);

   // All counters packed two bits per register; slot 0 is a constant zero so
   // lookups by any register number need no special case for r0.
   logic [63:0] cnt_flat;

   logic [1:0]  cnt_rs;
   logic [1:0]  cnt_rt;
   logic [1:0]  cnt_dest;
   logic [1:0]  cnt_wb;
   logic        same_cycle_inc_wb;
   logic        underflow_ev;

   logic [15:0] stall_cycles_q, stall_cycles_d;
   logic        err_underflow_q, err_underflow_d;

   assign cnt_rs   = cnt_flat[{rs, 1'b0} +: 2];
   assign cnt_rt   = cnt_flat[{rt, 1'b0} +: 2];
   assign cnt_dest = cnt_flat[{dest, 1'b0} +: 2];
   assign cnt_wb   = cnt_flat[{writereg_WB, 1'b0} +: 2];

   // No writeback bypass: a nonzero counter stalls even if it is being
   // decremented this very cycle.
   assign stall = issue_valid &
                  ((uses_rs & (cnt_rs != 2'd0)) |
                   (uses_rt & (cnt_rt != 2'd0)) |
                   (dest_we & (cnt_dest == 2'd3)));

   assign issue_accept = issue_valid & ~stall;

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_cnt
         if (gi == 0) begin : g_zero
            assign cnt_flat[1:0] = 2'd0;
         end else begin : g_reg
            logic [1:0] cnt_q, cnt_d;
            logic       inc, dec;

            assign inc = issue_accept & dest_we & (dest == 5'(gi));
            assign dec = regwrite_WB & (writereg_WB == 5'(gi));

            // Increment and decrement on the same register cancel out; a
            // lone decrement at zero is held at zero (flagged separately).
            always_comb begin
               cnt_d = cnt_q;
               if (flush) begin
                  cnt_d = 2'd0;
               end else if (inc && !dec) begin
                  cnt_d = cnt_q + 2'd1;
               end else if (dec && !inc && (cnt_q != 2'd0)) begin
                  cnt_d = cnt_q - 2'd1;
               end
            end

            always_ff @(posedge clk or negedge reset) begin
               if (!reset) begin
                  cnt_q <= 2'd0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            assign cnt_flat[2*gi +: 2] = cnt_q;
         end
      end
   endgenerate

   // Underflow only when the decrement would really take effect: a flush
   // discards it, and a same-cycle increment to that register cancels it.
   assign same_cycle_inc_wb = issue_accept & dest_we & (dest == writereg_WB);
   assign underflow_ev = ~flush & regwrite_WB & (writereg_WB != 5'd0) &
                         (cnt_wb == 2'd0) & ~same_cycle_inc_wb;

   always_comb begin
      err_underflow_d = err_underflow_q | underflow_ev;
      stall_cycles_d  = stall_cycles_q;
      if (stall && (stall_cycles_q != 16'hFFFF)) begin
         stall_cycles_d = stall_cycles_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles_q  <= 16'd0;
         err_underflow_q <= 1'b0;
      end else begin
         stall_cycles_q  <= stall_cycles_d;
         err_underflow_q <= err_underflow_d;
      end
   end

   assign pending_any   = |cnt_flat;
   assign stall_cycles  = stall_cycles_q;
   assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_decode_scoreboard
//
// Purpose: self-checking bench for decode_scoreboard. Directed scenarios for
// RAW stalls, register 0, WAW saturation, simultaneous inc/dec, flush and
// underflow, reset mid-operation and stall-counter saturation, plus a random
// run compared each cycle against an array-of-integers reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_decode_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  rs, rt, dest, writereg_WB;
   logic        uses_rs, uses_rt, dest_we, regwrite_WB, flush;
   logic        stall, issue_accept, pending_any, err_underflow;
   logic [15:0] stall_cycles;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: outstanding-write count per register, sticky error,
   // stalled-cycle total.
   int m_cnt [32];
   bit m_err;
   int m_sc;

   decode_scoreboard dut (
      .clk          (clk),
      .reset        (reset),
      .issue_valid  (issue_valid),
      .rs           (rs),
      .rt           (rt),
      .uses_rs      (uses_rs),
      .uses_rt      (uses_rt),
      .dest         (dest),
      .dest_we      (dest_we),
      .regwrite_WB  (regwrite_WB),
      .writereg_WB  (writereg_WB),
      .flush        (flush),
      .stall        (stall),
      .issue_accept (issue_accept),
      .pending_any  (pending_any),
      .stall_cycles (stall_cycles),
      .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   function automatic bit m_stall();
      bit hz;
      hz = 1'b0;
      if (uses_rs && rs != 0 && m_cnt[rs] > 0) hz = 1'b1;
      if (uses_rt && rt != 0 && m_cnt[rt] > 0) hz = 1'b1;
      if (dest_we && dest != 0 && m_cnt[dest] == 3) hz = 1'b1;
      return issue_valid && hz;
   endfunction

   function automatic bit m_pending();
      for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_err = 1'b0;
      m_sc  = 0;
   endtask

   // Apply the effect of the current inputs at the coming rising edge.
   task automatic model_tick();
      bit st, acc;
      int inc_r, dec_r;
      st  = m_stall();
      acc = issue_valid && !st;
      if (st && m_sc < 65535) m_sc++;
      if (flush) begin
         for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      end else begin
         inc_r = (acc && dest_we && dest != 0) ? int'(dest) : 0;
         dec_r = (regwrite_WB && writereg_WB != 0) ? int'(writereg_WB) : 0;
         if (!(inc_r != 0 && inc_r == dec_r)) begin
            if (inc_r != 0) m_cnt[inc_r]++;
            if (dec_r != 0) begin
               if (m_cnt[dec_r] > 0) m_cnt[dec_r]--;
               else m_err = 1'b1;
            end
         end
      end
   endtask

   task automatic finish_cycle();
      model_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit iv, input int rs_v, input bit urs, input int rt_v,
                         input bit urt, input int d, input bit dw, input bit wb,
                         input int wr, input bit fl);
      issue_valid = iv;
      rs          = rs_v[4:0];
      uses_rs     = urs;
      rt          = rt_v[4:0];
      uses_rt     = urt;
      dest        = d[4:0];
      dest_we     = dw;
      regwrite_WB = wb;
      writereg_WB = wr[4:0];
      flush       = fl;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Reset pulse starting just after a rising edge, released on a falling edge.
   task automatic apply_reset();
      idle();
      reset = 1'b0;
      model_clear();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // -----------------------------------------------------------------------
   task automatic test_reset();
      // Build outstanding writes to r5 and r6, then reset asynchronously.
      set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); finish_cycle();
      set_in(1, 0, 0, 0, 0, 6, 1, 0, 0, 0); finish_cycle();
      set_in(1, 5, 1, 6, 1, 0, 0, 0, 0, 0);
      #1;
      if (stall !== 1'b1) begin
         n_fail++; $display("FAIL reset_pre_stall: stall=%b expected 1", stall);
      end
      n_tests++;
      reset = 1'b0;
      model_clear();
      #1;
      if (stall !== 1'b0 || issue_accept !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_async_comb: stall=%b accept=%b expected 0/1", stall, issue_accept);
      end
      n_tests++;
      if (pending_any !== 1'b0 || stall_cycles !== 16'd0 || err_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async_state: pending=%b sc=%0d err=%b expected 0/0/0",
                  pending_any, stall_cycles, err_underflow);
      end
      n_tests++;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      // First cycle after release: r5/r6 readers issue freely.
      @(negedge clk);
      if (stall !== 1'b0 || issue_accept !== 1'b1 || pending_any !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: stall=%b accept=%b pending=%b expected 0/1/0",
                  stall, issue_accept, pending_any);
      end
      n_tests++;
      finish_cycle();
      $display("[TB] test_reset done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_raw();
      apply_reset();
      set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      @(negedge clk);
      if (issue_accept !== 1'b1) begin
         n_fail++; $display("FAIL raw_producer: accept=%b expected 1", issue_accept);
      end
      n_tests++;
      finish_cycle();
      set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (stall !== 1'b1 || issue_accept !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_wait[%0d]: stall=%b accept=%b expected 1/0", i, stall, issue_accept);
         end
         n_tests++;
         finish_cycle();
      end
      regwrite_WB = 1'b1; writereg_WB = 5'd5;
      @(negedge clk);
      if (stall !== 1'b1) begin
         n_fail++; $display("FAIL raw_no_bypass: stall=%b expected 1", stall);
      end
      n_tests++;
      finish_cycle();
      regwrite_WB = 1'b0;
      @(negedge clk);
      if (stall !== 1'b0 || issue_accept !== 1'b1 || pending_any !== 1'b0) begin
         n_fail++;
         $display("FAIL raw_release: stall=%b accept=%b pending=%b expected 0/1/0",
                  stall, issue_accept, pending_any);
      end
      n_tests++;
      if (stall_cycles !== 16'd4) begin
         n_fail++; $display("FAIL raw_stall_count: stall_cycles=%0d expected 4", stall_cycles);
      end
      n_tests++;
      finish_cycle();
      idle();
      $display("[TB] test_raw done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_reg0();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         set_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
         @(negedge clk);
         if (issue_accept !== 1'b1 || pending_any !== 1'b0) begin
            n_fail++;
            $display("FAIL reg0_write[%0d]: accept=%b pending=%b expected 1/0", i, issue_accept, pending_any);
         end
         n_tests++;
         finish_cycle();
      end
      set_in(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
      @(negedge clk);
      if (stall !== 1'b0 || pending_any !== 1'b0) begin
         n_fail++; $display("FAIL reg0_read: stall=%b pending=%b expected 0/0", stall, pending_any);
      end
      n_tests++;
      finish_cycle();
      idle();
      $display("[TB] test_reg0 done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_waw();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
         @(negedge clk);
         if (issue_accept !== 1'b1) begin
            n_fail++; $display("FAIL waw_fill[%0d]: accept=%b expected 1", i, issue_accept);
         end
         n_tests++;
         finish_cycle();
      end
      @(negedge clk);
      if (stall !== 1'b1 || issue_accept !== 1'b0) begin
         n_fail++; $display("FAIL waw_saturated: stall=%b accept=%b expected 1/0", stall, issue_accept);
      end
      n_tests++;
      finish_cycle();
      regwrite_WB = 1'b1; writereg_WB = 5'd7;
      @(negedge clk);
      if (stall !== 1'b1) begin
         n_fail++; $display("FAIL waw_wb_cycle: stall=%b expected 1", stall);
      end
      n_tests++;
      finish_cycle();
      regwrite_WB = 1'b0;
      @(negedge clk);
      if (issue_accept !== 1'b1) begin
         n_fail++; $display("FAIL waw_after_wb: accept=%b expected 1", issue_accept);
      end
      n_tests++;
      finish_cycle();
      // cnt[7] back at 3: another write to r7 must stall again.
      @(negedge clk);
      if (stall !== 1'b1 || pending_any !== 1'b1) begin
         n_fail++; $display("FAIL waw_back_to_3: stall=%b pending=%b expected 1/1", stall, pending_any);
      end
      n_tests++;
      finish_cycle();
      idle();
      $display("[TB] test_waw done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_simultaneous();
      apply_reset();
      set_in(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); finish_cycle();
      set_in(1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
      @(negedge clk);
      if (issue_accept !== 1'b1) begin
         n_fail++; $display("FAIL simul_accept: accept=%b expected 1", issue_accept);
      end
      n_tests++;
      finish_cycle();
      idle();
      @(negedge clk);
      if (pending_any !== 1'b1) begin
         n_fail++; $display("FAIL simul_pending: pending=%b expected 1", pending_any);
      end
      n_tests++;
      // Exactly one write left: one writeback empties it without error.
      regwrite_WB = 1'b1; writereg_WB = 5'd9;
      finish_cycle();
      idle();
      @(negedge clk);
      if (pending_any !== 1'b0 || err_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_cnt_is_1: pending=%b err=%b expected 0/0", pending_any, err_underflow);
      end
      n_tests++;
      finish_cycle();
      $display("[TB] test_simultaneous done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_flush_underflow();
      apply_reset();
      set_in(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); finish_cycle();
      finish_cycle();
      set_in(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); finish_cycle();
      // Flush cycle: stall still follows the current counters.
      set_in(1, 3, 1, 0, 0, 4, 1, 0, 0, 1);
      @(negedge clk);
      if (stall !== 1'b1 || pending_any !== 1'b1) begin
         n_fail++; $display("FAIL flush_cycle_stall: stall=%b pending=%b expected 1/1", stall, pending_any);
      end
      n_tests++;
      finish_cycle();
      set_in(1, 3, 1, 4, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (pending_any !== 1'b0 || issue_accept !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_cleared: pending=%b accept=%b expected 0/1", pending_any, issue_accept);
      end
      n_tests++;
      finish_cycle();
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
      @(negedge clk);
      if (err_underflow !== 1'b0) begin
         n_fail++; $display("FAIL underflow_early: err=%b expected 0", err_underflow);
      end
      n_tests++;
      finish_cycle();
      idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (err_underflow !== 1'b1) begin
            n_fail++; $display("FAIL underflow_sticky[%0d]: err=%b expected 1", i, err_underflow);
         end
         n_tests++;
         finish_cycle();
      end
      apply_reset();
      if (err_underflow !== 1'b0) begin
         n_fail++; $display("FAIL underflow_reset: err=%b expected 0", err_underflow);
      end
      n_tests++;
      $display("[TB] test_flush_underflow done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_random();
      int wr;
      int pend [$];
      apply_reset();
      for (int t = 0; t < 400; t++) begin
         pend.delete();
         for (int r = 1; r < 8; r++) if (m_cnt[r] > 0) pend.push_back(r);
         flush = ($urandom_range(99) < 3);
         regwrite_WB = !flush && ($urandom_range(99) < 40);
         if (pend.size() > 0 && $urandom_range(99) < 92)
            wr = pend[$urandom_range(pend.size() - 1)];
         else
            wr = $urandom_range(7);
         writereg_WB = wr[4:0];
         issue_valid = ($urandom_range(99) < 75);
         rs          = 5'($urandom_range(7));
         rt          = 5'($urandom_range(7));
         dest        = 5'($urandom_range(7));
         uses_rs     = 1'($urandom_range(1));
         uses_rt     = 1'($urandom_range(1));
         dest_we     = ($urandom_range(99) < 70);
         @(negedge clk);
         $display("[TB] rnd %0d iv=%b rs=%0d/%b rt=%0d/%b d=%0d/%b wb=%b/%0d fl=%b stall=%b acc=%b",
                  t, issue_valid, rs, uses_rs, rt, uses_rt, dest, dest_we,
                  regwrite_WB, writereg_WB, flush, stall, issue_accept);
         if (stall !== m_stall() || issue_accept !== (issue_valid && !m_stall())) begin
            n_fail++;
            $display("FAIL rnd_comb[%0d]: stall=%b accept=%b expected %b/%b", t, stall,
                     issue_accept, m_stall(), issue_valid && !m_stall());
         end
         n_tests++;
         if (pending_any !== m_pending() || err_underflow !== m_err ||
             stall_cycles !== 16'(m_sc)) begin
            n_fail++;
            $display("FAIL rnd_state[%0d]: pending=%b err=%b sc=%0d expected %b/%b/%0d", t,
                     pending_any, err_underflow, stall_cycles, m_pending(), m_err, m_sc);
         end
         n_tests++;
         finish_cycle();
      end
      idle();
      $display("[TB] test_random done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_stall_sat();
      apply_reset();
      set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); finish_cycle();
      set_in(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 70000; i++) begin
         finish_cycle();
         if (i == 1000 || i == 65534 || i == 65535 || i == 70000) begin
            if (stall_cycles !== 16'(m_sc)) begin
               n_fail++;
               $display("FAIL stall_sat[%0d]: stall_cycles=%0d expected %0d", i, stall_cycles, m_sc);
            end
            n_tests++;
         end
      end
      if (stall_cycles !== 16'hFFFF || stall !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_sat_final: stall_cycles=%h stall=%b expected ffff/1", stall_cycles, stall);
      end
      n_tests++;
      idle();
      $display("[TB] test_stall_sat done");
   endtask

   initial begin
      idle();
      model_clear();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (pending_any !== 1'b0 || stall_cycles !== 16'd0 || err_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL power_on_reset: pending=%b sc=%0d err=%b expected 0/0/0",
                  pending_any, stall_cycles, err_underflow);
      end
      n_tests++;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_raw();
      test_reg0();
      test_waw();
      test_simultaneous();
      test_flush_underflow();
      test_random();
      test_stall_sat();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
